// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - receiver/FIFO/status bundle for uart_rx_ctrl
//
// Purpose: groups every non-clock signal of uart_rx_ctrl. The slave modport is
// the controller's view; the master modport is the view of whoever drives the
// receiver side and reads the FIFO/status (receiver + register block, or a bench).
//
// Signals (controller view):
//   enable     in   software receive enable
//   rx_done    in   one-cycle pulse, rx_data valid
//   rx_data    in   received byte
//   rx_busy    in   receiver mid-frame
//   rx_en      out  enable to receiver
//   pop        in   consume head entry
//   pop_data   out  head entry (first-word fall-through)
//   fifo_empty out  FIFO empty
//   fifo_full  out  FIFO full
//   fifo_level out  entries held
//   ovr_clr    in   clears overrun
//   overrun    out  sticky byte-dropped flag
//   timeout    out  idle timeout flag
//   irq        out  interrupt request
interface uart_rx_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int LVL_WIDTH  = $clog2(FIFO_DEPTH) + 1
);
   logic                  enable;
   logic                  rx_done;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_busy;
   logic                  rx_en;
   logic                  pop;
   logic [DATA_WIDTH-1:0] pop_data;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic [LVL_WIDTH-1:0]  fifo_level;
   logic                  ovr_clr;
   logic                  overrun;
   logic                  timeout;
   logic                  irq;

   modport slave (
      input  enable, rx_done, rx_data, rx_busy, pop, ovr_clr,
      output rx_en, pop_data, fifo_empty, fifo_full, fifo_level, overrun, timeout, irq
   );

   modport master (
      output enable, rx_done, rx_data, rx_busy, pop, ovr_clr,
      input  rx_en, pop_data, fifo_empty, fifo_full, fifo_level, overrun, timeout, irq
   );
endinterface

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencing, FWFT byte FIFO and status flags
//
// Purpose: enables the UART receiver, captures every rx_done byte into a small
// first-word-fall-through FIFO, throttles the receiver while the FIFO is full,
// flags dropped bytes (overrun) and an optional idle timeout, and raises irq.
//
// Ports:
//   clk  in  clock
//   rst  in  asynchronous reset, active-high
//   bus  uart_rx_ctrl_if.slave (enable, rx_done, rx_data, rx_busy, pop, ovr_clr in;
//        rx_en, pop_data, fifo_empty, fifo_full, fifo_level, overrun, timeout, irq out)
//
// Configuration macro: UART_RX_CTRL_TIMEOUT_EN enables the idle timeout counter;
// when undefined, timeout is tied low.
module uart_rx_ctrl #(
   parameter int DATA_WIDTH     = 8,
   parameter int FIFO_DEPTH     = 4,
   parameter int LVL_WIDTH      = $clog2(FIFO_DEPTH) + 1,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int IRQ_THRESH     = 2
) (
   input logic           clk,
   input logic           rst,
   uart_rx_ctrl_if.slave bus
);

   localparam int PTR_W = LVL_WIDTH - 1;

   localparam logic [1:0] ST_OFF   = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_RECV  = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [PTR_W-1:0]      wptr_q, wptr_d;
   logic [PTR_W-1:0]      rptr_q, rptr_d;
   logic [LVL_WIDTH-1:0]  level_q, level_d;
   logic                  overrun_q, overrun_d;
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

   logic empty, full;
   logic do_push, do_pop, drop;

   assign empty = (level_q == '0);
   assign full  = (level_q == LVL_WIDTH'(FIFO_DEPTH));

   // A push into a full FIFO is only accepted when the head leaves the same cycle.
   assign do_pop  = bus.pop & ~empty;
   assign do_push = bus.rx_done & (~full | bus.pop);
   assign drop    = bus.rx_done & full & ~bus.pop;

   // ---------------- receiver sequencing ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_OFF:   if (bus.enable) state_d = ST_ARMED;
         ST_ARMED: begin
            if (!bus.enable)     state_d = ST_OFF;
            else if (full)       state_d = ST_HOLD;
            else if (bus.rx_busy) state_d = ST_RECV;
         end
         // A frame in progress always runs to completion, even if enable drops.
         ST_RECV:  begin
            if (!bus.rx_busy) begin
               if (!bus.enable) state_d = ST_OFF;
               else if (full)   state_d = ST_HOLD;
               else             state_d = ST_ARMED;
            end
         end
         ST_HOLD:  begin
            if (!bus.enable) state_d = ST_OFF;
            else if (!full)  state_d = ST_ARMED;
         end
         default:  state_d = ST_OFF;
      endcase
   end

   // ---------------- FIFO bookkeeping ----------------
   always_comb begin
      wptr_d    = do_push ? wptr_q + PTR_W'(1) : wptr_q;
      rptr_d    = do_pop  ? rptr_q + PTR_W'(1) : rptr_q;
      level_d   = level_q + LVL_WIDTH'(do_push) - LVL_WIDTH'(do_pop);
      // Setting takes priority over a same-cycle clear.
      overrun_d = drop ? 1'b1 : (bus.ovr_clr ? 1'b0 : overrun_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_OFF;
         wptr_q    <= '0;
         rptr_q    <= '0;
         level_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         level_q   <= level_d;
         overrun_q <= overrun_d;
      end
   end

   // Storage needs no reset: an empty FIFO masks its contents on pop_data.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr_q] <= bus.rx_data;
   end

   // ---------------- idle timeout ----------------
   logic timeout_flag;

`ifdef UART_RX_CTRL_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;
   logic             at_limit;

   assign at_limit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      if (bus.rx_done || bus.pop || bus.rx_busy || empty) cnt_d = '0;
      else if (!at_limit)                                 cnt_d = cnt_q + CNT_W'(1);
      // Only draining the FIFO clears the flag; receiver activity does not.
      if (bus.pop || empty)  timeout_d = 1'b0;
      else if (at_limit)     timeout_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_flag = timeout_q;
`else
   assign timeout_flag = 1'b0;
`endif

   // ---------------- outputs ----------------
   assign bus.rx_en      = (state_q == ST_ARMED) | (state_q == ST_RECV);
   assign bus.pop_data   = empty ? '0 : mem[rptr_q];
   assign bus.fifo_empty = empty;
   assign bus.fifo_full  = full;
   assign bus.fifo_level = level_q;
   assign bus.overrun    = overrun_q;
   assign bus.timeout    = timeout_flag;
   assign bus.irq        = (level_q >= LVL_WIDTH'(IRQ_THRESH)) | timeout_flag | overrun_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

   localparam int DW = 8;
   localparam int DEPTH = 4;
   localparam int LW = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   uart_rx_ctrl_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .LVL_WIDTH(LW)) bus ();

   uart_rx_ctrl #(
      .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .LVL_WIDTH(LW),
      .TIMEOUT_CYCLES(16), .IRQ_THRESH(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_b(input logic [7:0] d);
      bus.rx_done = 1'b1;
      bus.rx_data = d;
      tick();
      bus.rx_done = 1'b0;
   endtask

   task automatic pop_chk(input string tag, input logic [7:0] exp);
      chk(tag, bus.pop_data, exp);
      bus.pop = 1'b1;
      tick();
      bus.pop = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_rx_en"}, bus.rx_en, 0);
      chk({tag, "_empty"}, bus.fifo_empty, 1);
      chk({tag, "_full"}, bus.fifo_full, 0);
      chk({tag, "_level"}, bus.fifo_level, 0);
      chk({tag, "_pdata"}, bus.pop_data, 0);
      chk({tag, "_ovr"}, bus.overrun, 0);
      chk({tag, "_tmo"}, bus.timeout, 0);
      chk({tag, "_irq"}, bus.irq, 0);
   endtask

   initial begin
      bus.enable  = 1'b0;
      bus.rx_done = 1'b0;
      bus.rx_data = '0;
      bus.rx_busy = 1'b0;
      bus.pop     = 1'b0;
      bus.ovr_clr = 1'b0;
      tick(2);
      chk_reset("rst");
      rst = 1'b0;

      // 1: single byte round trip
      bus.enable = 1'b1;
      tick();
      chk("t1_rx_en", bus.rx_en, 1);
      bus.rx_busy = 1'b1;
      tick();
      bus.rx_busy = 1'b0;
      bus.rx_done = 1'b1;
      bus.rx_data = 8'hA5;
      tick();
      bus.rx_done = 1'b0;
      chk("t1_level", bus.fifo_level, 1);
      chk("t1_pdata", bus.pop_data, 8'hA5);
      chk("t1_empty", bus.fifo_empty, 0);
      chk("t1_irq1", bus.irq, 0);
      bus.pop = 1'b1;
      tick();
      bus.pop = 1'b0;
      chk("t1_level0", bus.fifo_level, 0);
      chk("t1_empty1", bus.fifo_empty, 1);
      chk("t1_pdata0", bus.pop_data, 0);

      // 2: fill, throttle, release
      push_b(8'h01);
      chk("t2_irq_l1", bus.irq, 0);
      push_b(8'h02);
      chk("t2_irq_l2", bus.irq, 1);
      push_b(8'h03);
      push_b(8'h04);
      chk("t2_full", bus.fifo_full, 1);
      chk("t2_level4", bus.fifo_level, 4);
      tick();
      chk("t2_hold_rx_en", bus.rx_en, 0);
      chk("t2_irq_full", bus.irq, 1);
      pop_chk("t2_head01", 8'h01);
      chk("t2_head02", bus.pop_data, 8'h02);
      chk("t2_level3", bus.fifo_level, 3);
      chk("t2_irq_l3", bus.irq, 1);
      tick();
      chk("t2_rearm", bus.rx_en, 1);
      pop_chk("t2_d02", 8'h02);
      pop_chk("t2_d03", 8'h03);
      pop_chk("t2_d04", 8'h04);
      chk("t2_empty", bus.fifo_empty, 1);

      // 3: overrun set / clear / set-wins
      push_b(8'h10);
      push_b(8'h11);
      push_b(8'h12);
      push_b(8'h13);
      bus.rx_busy = 1'b1;
      push_b(8'hFF);
      chk("t3_ovr", bus.overrun, 1);
      chk("t3_level", bus.fifo_level, 4);
      chk("t3_head", bus.pop_data, 8'h10);
      bus.ovr_clr = 1'b1;
      tick();
      chk("t3_ovr_clr", bus.overrun, 0);
      bus.rx_done = 1'b1;
      bus.rx_data = 8'hFF;
      tick();
      bus.rx_done = 1'b0;
      chk("t3_set_wins", bus.overrun, 1);
      chk("t3_level_b", bus.fifo_level, 4);
      tick();
      bus.ovr_clr = 1'b0;
      chk("t3_ovr_clr2", bus.overrun, 0);
      bus.rx_busy = 1'b0;
      pop_chk("t3_d10", 8'h10);
      pop_chk("t3_d11", 8'h11);
      pop_chk("t3_d12", 8'h12);
      pop_chk("t3_d13", 8'h13);
      chk("t3_empty", bus.fifo_empty, 1);

      // 4: simultaneous push+pop at full and at empty
      push_b(8'h20);
      push_b(8'h21);
      push_b(8'h22);
      push_b(8'h23);
      bus.pop = 1'b1;
      push_b(8'h55);
      bus.pop = 1'b0;
      chk("t4_level_full", bus.fifo_level, 4);
      chk("t4_no_ovr", bus.overrun, 0);
      pop_chk("t4_d21", 8'h21);
      pop_chk("t4_d22", 8'h22);
      pop_chk("t4_d23", 8'h23);
      pop_chk("t4_d55", 8'h55);
      chk("t4_empty", bus.fifo_empty, 1);
      bus.pop = 1'b1;
      push_b(8'h66);
      bus.pop = 1'b0;
      chk("t4_level_e", bus.fifo_level, 1);
      chk("t4_head66", bus.pop_data, 8'h66);
      pop_chk("t4_d66", 8'h66);
      bus.pop = 1'b1;
      tick();
      bus.pop = 1'b0;
      chk("t4_underflow", bus.fifo_level, 0);
      chk("t4_empty2", bus.fifo_empty, 1);

      // 5: idle timeout
      push_b(8'h77);
      tick(15);
      chk("t5_tmo_early", bus.timeout, 0);
      tick();
`ifdef UART_RX_CTRL_TIMEOUT_EN
      chk("t5_tmo", bus.timeout, 1);
      chk("t5_irq", bus.irq, 1);
`else
      chk("t5_tmo_off", bus.timeout, 0);
      chk("t5_irq_off", bus.irq, 0);
`endif
      pop_chk("t5_d77", 8'h77);
      chk("t5_tmo_clr", bus.timeout, 0);
      chk("t5_irq_clr", bus.irq, 0);

      // 6: enable drop mid-frame, then reset mid-frame
      bus.rx_busy = 1'b1;
      tick();
      bus.enable = 1'b0;
      tick();
      chk("t6_rx_en_hold", bus.rx_en, 1);
      bus.rx_busy = 1'b0;
      push_b(8'h88);
      chk("t6_off", bus.rx_en, 0);
      chk("t6_level", bus.fifo_level, 1);
      chk("t6_head", bus.pop_data, 8'h88);
      bus.enable = 1'b1;
      tick();
      bus.rx_busy = 1'b1;
      tick();
      push_b(8'h99);
      chk("t6_level2", bus.fifo_level, 2);
      chk("t6_recv", bus.rx_en, 1);
      rst = 1'b1;
      tick();
      chk_reset("t6_rst");
      rst = 1'b0;
      bus.rx_busy = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
